// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data requesters share one memory bus.
// Ties alternate between requesters, and stalled transactions are aborted by a wait counter.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } state_t;

  // The counter sits at LIMIT during the last cycle a grant may wait before it is aborted.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic        last_grant_data, last_grant_data_d;
  logic [15:0] wait_cnt, wait_cnt_d;
  logic        mem_valid_d, mem_instr_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;
  logic        i_ready_d, d_ready_d;
  logic [31:0] i_rdata_d, d_rdata_d;
  logic        timeout_d;

  // State and every output are registered; all next values are computed below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant_data <= 1'b1;
      wait_cnt        <= '0;
      mem_valid       <= 1'b0;
      mem_instr       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
      i_ready         <= 1'b0;
      d_ready         <= 1'b0;
      i_rdata         <= '0;
      d_rdata         <= '0;
      timeout         <= 1'b0;
    end else begin
      state           <= state_d;
      last_grant_data <= last_grant_data_d;
      wait_cnt        <= wait_cnt_d;
      mem_valid       <= mem_valid_d;
      mem_instr       <= mem_instr_d;
      mem_addr        <= mem_addr_d;
      mem_wdata       <= mem_wdata_d;
      mem_wstrb       <= mem_wstrb_d;
      i_ready         <= i_ready_d;
      d_ready         <= d_ready_d;
      i_rdata         <= i_rdata_d;
      d_rdata         <= d_rdata_d;
      timeout         <= timeout_d;
    end
  end

  always_comb begin
    state_d           = state;
    last_grant_data_d = last_grant_data;
    wait_cnt_d        = wait_cnt;
    mem_valid_d       = mem_valid;
    mem_instr_d       = mem_instr;
    mem_addr_d        = mem_addr;
    mem_wdata_d       = mem_wdata;
    mem_wstrb_d       = mem_wstrb;
    i_ready_d         = 1'b0;
    d_ready_d         = 1'b0;
    i_rdata_d         = i_rdata;
    d_rdata_d         = d_rdata;
    timeout_d         = timeout;

    case (state)
      IDLE: begin
        // On a tie the fetch side wins only if data was served last.
        if (i_valid && (!d_valid || last_grant_data)) begin
          state_d     = GNT_I;
          mem_valid_d = 1'b1;
          mem_instr_d = 1'b1;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          wait_cnt_d  = '0;
        end else if (d_valid) begin
          state_d     = GNT_D;
          mem_valid_d = 1'b1;
          mem_instr_d = 1'b0;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          wait_cnt_d  = '0;
        end
      end

      GNT_I, GNT_D: begin
        // A completion arriving on the limit edge still counts as a normal completion.
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          if (state == GNT_I) begin
            i_ready_d         = 1'b1;
            i_rdata_d         = mem_rdata;
            last_grant_data_d = 1'b0;
          end else begin
            d_ready_d         = 1'b1;
            d_rdata_d         = mem_rdata;
            last_grant_data_d = 1'b1;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          timeout_d   = 1'b1;
          if (state == GNT_I) begin
            i_ready_d         = 1'b1;
            i_rdata_d         = '0;
            last_grant_data_d = 1'b0;
          end else begin
            d_ready_d         = 1'b1;
            d_rdata_d         = '0;
            last_grant_data_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt + 16'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles a granted transaction waits for mem_ready before abort (range 1..65535).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  fetch request pending; held high until i_ready pulse.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_ready  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata  output  32  fetch read data, valid while i_ready high.
REQ-008 d_valid  input  1  data load/store request pending; held high until d_ready pulse.
REQ-009 d_addr  input  32  data address.
REQ-010 d_wdata  input  32  store data.
REQ-011 d_wstrb  input  4  byte write strobes; 0 = load.
REQ-012 d_ready  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  load data, valid while d_ready high.
REQ-014 mem_valid  output  1  memory request active.
REQ-015 mem_instr  output  1  1 = active request is a fetch.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_wstrb  output  4  memory byte strobes.
REQ-019 mem_ready  input  1  memory completion; sampled only while mem_valid high.
REQ-020 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-021 timeout  output  1  sticky error flag: a transaction was aborted.

Function
REQ-022 States: IDLE, GNT_I, GNT_D, RESP; all outputs registered.
REQ-023 IDLE, only i_valid: latch i_addr, mem_instr=1, mem_wstrb=0, mem_wdata=0, go GNT_I; mem_valid high next cycle.
REQ-024 IDLE, only d_valid: latch d_addr/d_wdata/d_wstrb, mem_instr=0, go GNT_D.
REQ-025 IDLE, both valid: grant requester not served last (last_grant register); last_grant resets to data, so fetch wins first tie after reset.
REQ-026 mem_addr/mem_wdata/mem_wstrb/mem_instr stable for the whole time mem_valid is high; requester input changes ignored after grant.
REQ-027 GNT_x, mem_ready high at edge: mem_valid low, capture mem_rdata into x_rdata, x_ready=1, go RESP, last_grant=x.
REQ-028 RESP lasts exactly one cycle, no grant issued in it; then IDLE; x_ready and other ready low outside RESP.
REQ-029 Min latency: request seen at edge k -> mem_valid high cycle k+1; mem_ready at edge m -> ready pulse cycle m+1; back-to-back grants separated by >= 2 idle-bus cycles.
REQ-030 Wait counter (16 bit) clears on grant, increments each GNT_x cycle without mem_ready.
REQ-031 Counter reaching TIMEOUT_CYCLES without mem_ready: abort -> mem_valid low, x_ready pulse with x_rdata=0, timeout set, go RESP.
REQ-032 mem_ready and counter limit at same edge: normal completion wins, timeout unchanged.
REQ-033 mem_ready while mem_valid low or in RESP/IDLE: ignored, no state change.
REQ-034 timeout cleared only by reset.
REQ-035 Non-granted requester stalls with no ready pulse; starvation bounded to one transaction by REQ-025.

Reset
REQ-036 reset high at edge: state IDLE, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, timeout=0, counter=0, last_grant=data.
REQ-037 Reset mid-transaction: abort without ready pulse; mem_valid low the cycle after the reset edge.

Verification
REQ-038 Fetch only: i_valid, i_addr=0x100, mem_ready 2 cycles later with rdata=0x00000013 -> mem_instr=1, mem_wstrb=0, i_ready one cycle, i_rdata=0x13.
REQ-039 Store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_* match latched values, d_ready one cycle, i_ready never high.
REQ-040 Tie after reset: both valid continuously, mem_ready immediate -> grant order I, D, I, D; each ready single-cycle.
REQ-041 Timeout: TIMEOUT_CYCLES=4, data load, mem_ready never -> mem_valid high 4 cycles, then d_ready with d_rdata=0, timeout=1 held until reset.
REQ-042 Reset during GNT_D with mem_valid high -> mem_valid=0 next cycle, no d_ready pulse, all outputs at REQ-036 values.
REQ-043 Boundary: mem_ready and counter limit same edge -> normal completion, d_rdata=mem_rdata, timeout stays 0.
